// File: rtl/pipelined_adder_tree.sv
// Registered binary adder tree reducing NUM lanes per beat, followed by a group accumulator.
// Optional signed-overflow tracking is compiled in with `define ADDER_TREE_OVF_EN.
module pipelined_adder_tree #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM        = 8,
    parameter int BEAT_W     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic [NUM-1:0][DATA_WIDTH-1:0]  data_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [BEAT_W-1:0]               beats_out
`ifdef ADDER_TREE_OVF_EN
    ,
    output logic                            ovf_out
`endif
);
    localparam int S     = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int NODES = (NUM > 1) ? NUM - 1 : 1;
    localparam int MSB   = DATA_WIDTH - 1;

    if (NUM < 2 || (NUM & (NUM - 1)) != 0) begin : g_param_chk
        $error("pipelined_adder_tree: NUM must be a power of two and >= 2");
    end

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // All tree nodes live in one flat array, stage by stage; the root is the last entry.
    logic [DATA_WIDTH-1:0] w_sum [NODES];
    logic [DATA_WIDTH-1:0] r_sum [NODES];
    logic [S-1:0]          r_vld;
    logic [S-1:0]          r_last;
`ifdef ADDER_TREE_OVF_EN
    logic [NODES-1:0]      w_ovf;
    logic [NODES-1:0]      r_ovf;
`endif

    genvar k, i;
    for (k = 0; k < S; k++) begin : g_stg
        localparam int IB = (k == 0) ? 0 : 2*NUM - 2*(NUM >> k) - NUM;
        localparam int OB = 2*NUM - 2*(NUM >> (k+1)) - NUM;
        for (i = 0; i < (NUM >> (k+1)); i++) begin : g_node
            logic [DATA_WIDTH-1:0] w_a;
            logic [DATA_WIDTH-1:0] w_b;
            if (k == 0) begin : g_leaf
                assign w_a = data_in[2*i];
                assign w_b = data_in[2*i+1];
            end else begin : g_inner
                assign w_a = r_sum[IB+2*i];
                assign w_b = r_sum[IB+2*i+1];
            end
            assign w_sum[OB+i] = w_a + w_b;
`ifdef ADDER_TREE_OVF_EN
            logic w_o;
            assign w_o = (w_a[MSB] == w_b[MSB]) && (w_sum[OB+i][MSB] != w_a[MSB]);
            if (k == 0) begin : g_leaf_ovf
                assign w_ovf[OB+i] = w_o;
            end else begin : g_inner_ovf
                assign w_ovf[OB+i] = w_o | r_ovf[IB+2*i] | r_ovf[IB+2*i+1];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_last <= '0;
            for (int n = 0; n < NODES; n++) r_sum[n] <= '0;
        end else if (w_adv) begin
            r_sum     <= w_sum;
            r_vld[0]  <= in_valid;
            r_last[0] <= in_last;
            for (int n = 1; n < S; n++) begin
                r_vld[n]  <= r_vld[n-1];
                r_last[n] <= r_last[n-1];
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_tree;
    logic [DATA_WIDTH-1:0] w_total;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [BEAT_W-1:0]     w_cnt_nxt;
    logic [BEAT_W-1:0]     r_cnt;
    logic                  r_first;
    logic                  w_done;

    assign w_tree    = r_sum[NODES-1];
    assign w_total   = r_first ? w_tree : r_acc + w_tree;
    assign w_cnt_nxt = r_first ? BEAT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
    assign w_done    = r_vld[S-1] && r_last[S-1];

    // out_valid follows w_done on every advance: a completing group reloads it, otherwise the handshake clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_first   <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= '0;
            beats_out <= '0;
        end else if (w_adv) begin
            out_valid <= w_done;
            if (r_vld[S-1]) begin
                if (r_last[S-1]) begin
                    data_out  <= w_total;
                    beats_out <= w_cnt_nxt;
                    r_first   <= 1'b1;
                end else begin
                    r_acc     <= w_total;
                    r_cnt     <= w_cnt_nxt;
                    r_first   <= 1'b0;
                end
            end
        end
    end

`ifdef ADDER_TREE_OVF_EN
    logic w_acc_ovf;
    logic w_tot_ovf;
    logic r_acc_ovf;

    assign w_acc_ovf = !r_first && (r_acc[MSB] == w_tree[MSB]) && (w_total[MSB] != r_acc[MSB]);
    assign w_tot_ovf = r_ovf[NODES-1] | (!r_first && r_acc_ovf) | w_acc_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= '0;
            r_acc_ovf <= 1'b0;
            ovf_out   <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf;
            if (r_vld[S-1]) begin
                if (r_last[S-1]) ovf_out   <= w_tot_ovf;
                else             r_acc_ovf <= w_tot_ovf;
            end
        end
    end
`endif

endmodule
